moore_seq_tx: RTL and testbench
===============================

# moore_seq_tx

Serial stimulus transmitter for the team's 4-state E-input Moore detectors (s0–s3, outputs A/B/Q). The block accepts a bit pattern over a valid/ready load handshake and drives it LSB-first onto a single-bit E line. Each bit is held for a programmable number of clocks, and the pattern can be looped. It sits on the driving side of a detector's E input, replacing hand-written bench stimulus and on-chip test sources.

## Interface
- WIDTH, 8: maximum pattern length in bits.
- HOLD, 2: clocks each bit is held on E; must be ≥1.
- LW, $clog2(WIDTH+1): width of LEN.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- LOAD_VALID  input  1  pattern offered.
- LOAD_READY  output  1  block can accept a pattern.
- PATTERN  input  WIDTH  bits to send; bit 0 is sent first.
- LEN  input  LW  number of bits to send; 0 or >WIDTH means WIDTH.
- REPEAT  input  1  loop the pattern until STOP.
- STOP  input  1  ends looping after the current pass.
- E  output  1  serial data to the detector.
- E_VALID  output  1  E carries pattern data.
- BUSY  output  1  state ≠ IDLE.
- DONE  output  1  one-cycle pulse when transmission ends.

## Operation
- States: IDLE, SEND, FIN. All outputs are Moore, decoded from registered state, shift register and flags.
- **IDLE**
  - LOAD_READY=1; E=0, E_VALID=0, BUSY=0, DONE=0.
  - On LOAD_VALID&&LOAD_READY: latch PATTERN into the shift register and into a saved copy.
  - Latch the effective LEN (clamped) and REPEAT into rep_f.
  - Clear bit_idx and hold_cnt; go to SEND.
- **SEND**
  - LOAD_READY=0, BUSY=1, E_VALID=1, E=shreg[0].
  - hold_cnt counts 0..HOLD-1. At HOLD-1: shift right, increment bit_idx, clear hold_cnt.
  - At the boundary where bit_idx==len-1:
    - rep_f=1: reload shreg from the saved copy, bit_idx=0, stay in SEND. There is no gap cycle.
    - rep_f=0: go to FIN.
  - STOP=1 in any SEND cycle clears rep_f; the current pass completes.
  - STOP and the wrap boundary in the same cycle: no reload; go to FIN.
  - LOAD_VALID is ignored; PATTERN/LEN/REPEAT changes have no effect.
- **FIN**
  - DONE=1, BUSY=1, E=0, E_VALID=0, LOAD_READY=0. Always goes to IDLE next cycle.
- STOP in IDLE or FIN has no effect. REPEAT=1 with STOP already high at load sends exactly one pass.
- Counter widths: hold_cnt is $clog2(HOLD+1) bits; bit_idx is LW bits. Neither counter exceeds its terminal value.

## Timing
- Reset:
  - RST_N low at a rising edge forces IDLE and clears shreg, saved copy, counters and rep_f.
  - After that edge: LOAD_READY=1 and all other outputs 0, including when reset is held.
  - Reset mid-SEND aborts immediately, with no DONE pulse.
  - Outputs are undefined before the first clock edge.
- Load accepted at edge k:
  - bit i is on E in cycles k+1+i·HOLD … k+(i+1)·HOLD.
  - DONE is high in cycle k+1+len·HOLD.
  - LOAD_READY is high again from cycle k+2+len·HOLD.
- Load-to-first-bit latency is 1 cycle.
- Minimum spacing between two non-repeat loads is len·HOLD+2 cycles.
- In repeat mode, pass p bit i starts at cycle k+1+(p·len+i)·HOLD.

## Test plan
- **Reset mid-SEND.** Load 8'hA5, LEN=8, drop RST_N for 1 edge during bit 3 → next cycle E_VALID=0, BUSY=0, LOAD_READY=1, and no DONE ever.
- **Basic send.** PATTERN=8'b0000_0110, LEN=4, HOLD=2, load at edge k → E over cycles k+1..k+8 = 0,0,1,1,1,1,0,0; DONE only in k+9; LOAD_READY=1 in k+10.
- **LEN clamp.** LEN=0 and LEN=15 (WIDTH=8), PATTERN=8'h81 → 8 bits, 1 then six 0s then 1, 16 E_VALID cycles each time.
- **Repeat and STOP.** REPEAT=1, LEN=3, PATTERN=3'b011, HOLD=1 → E=1,1,0,1,1,0… with no gaps. STOP pulsed during the second bit of pass 3 → pass 3 completes, DONE in the next cycle, exactly 9 E_VALID cycles.
- **Load while busy.** LOAD_VALID with PATTERN=8'hFF during SEND of 8'h00 → ignored, LOAD_READY=0, E stays 0 for the full pass.
- **Loop-back.** Drive a 4-state Moore detector from E with PATTERN=3'b110, LEN=3, HOLD=2 → detector passes s1→s2→s3 and asserts Q=1 within 2 clocks after the third bit begins.

Source files
------------

// File: rtl/moore_seq_tx.sv
// moore_seq_tx: serial stimulus source for the E input of the 4-state Moore
// detectors. A pattern accepted over the LOAD handshake is shifted out
// LSB-first on E. Each bit is held for HOLD clocks. The pattern can loop
// until STOP is seen.
//
// Load handshake: a pattern transfers on a rising edge where LOAD_VALID and
// LOAD_READY are both high. LOAD_READY is high only in IDLE. While the block
// is busy, LOAD_VALID and the PATTERN/LEN/REPEAT inputs are ignored.
module moore_seq_tx #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LW-1:0]    LEN,
  input  logic             REPEAT,
  input  logic             STOP,
  output logic             E,
  output logic             E_VALID,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       STATE_DBG
);

  localparam int HW = $clog2(HOLD + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] saved;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    bit_idx;
  logic [HW-1:0]    hold_cnt;
  logic             rep_f;
  logic [LW-1:0]    len_eff;

  // A length of zero, or one longer than the register, means a full-width pattern.
  always_comb begin
    len_eff = LEN;
    if ((LEN == '0) || (LEN > LW'(WIDTH))) begin
      len_eff = LW'(WIDTH);
    end
  end

  // Sequencer: load in IDLE, hold/shift/wrap in SEND, one DONE cycle in FIN.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      shreg    <= '0;
      saved    <= '0;
      len_q    <= '0;
      bit_idx  <= '0;
      hold_cnt <= '0;
      rep_f    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD_VALID) begin
            shreg    <= PATTERN;
            saved    <= PATTERN;
            len_q    <= len_eff;
            rep_f    <= REPEAT;
            bit_idx  <= '0;
            hold_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // STOP only cancels looping; the pass in flight always completes.
          if (STOP) begin
            rep_f <= 1'b0;
          end
          if (hold_cnt == HW'(HOLD - 1)) begin
            hold_cnt <= '0;
            if (bit_idx == len_q - 1'b1) begin
              // STOP on the wrap cycle wins over the registered loop flag.
              if (rep_f && !STOP) begin
                shreg   <= saved;
                bit_idx <= '0;
              end else begin
                state <= FIN;
              end
            end else begin
              shreg   <= {1'b0, shreg[WIDTH-1:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore outputs, decoded from registered state only.
  always_comb begin
    LOAD_READY = (state == IDLE);
    E_VALID    = (state == SEND);
    E          = (state == SEND) & shreg[0];
    BUSY       = (state != IDLE);
    DONE       = (state == FIN);
    STATE_DBG  = state;
  end

endmodule

// File: tb/tb_moore_seq_tx.sv
// Bench for moore_seq_tx. A driver loads patterns and pushes the expected E
// stream and the expected DONE cycle into queues. A monitor pops from these
// queues and compares them with the DUT on every falling edge.
module tb_moore_seq_tx;

  localparam int WIDTH = 8;
  localparam int HOLD  = 2;
  localparam int LW    = $clog2(WIDTH + 1);

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic [WIDTH-1:0] PATTERN;
  logic [LW-1:0]    LEN;
  logic             REPEAT;
  logic             STOP;
  logic             E;
  logic             E_VALID;
  logic             BUSY;
  logic             DONE;
  logic [1:0]       STATE_DBG;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  logic exp_q[$];
  int   done_q[$];
  logic mon_b;
  int   mon_d;

  moore_seq_tx #(.WIDTH(WIDTH), .HOLD(HOLD), .LW(LW)) dut (
    .CLK(CLK), .RST_N(RST_N), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .PATTERN(PATTERN), .LEN(LEN), .REPEAT(REPEAT), .STOP(STOP),
    .E(E), .E_VALID(E_VALID), .BUSY(BUSY), .DONE(DONE), .STATE_DBG(STATE_DBG)
  );

  // Clock and rising-edge counter.
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=present expected=absent (edge %0d)", name, cyc);
  endtask

  // Monitor: scoreboard pops plus invariants that hold every cycle.
  always @(negedge CLK) begin
    if (mon_en) begin
      check("ready_vs_busy", LOAD_READY, !BUSY);
      if (E_VALID) begin
        if (exp_q.size() == 0) flag_fail("unexpected_bit");
        else begin
          mon_b = exp_q.pop_front();
          check("e_bit", E, mon_b);
        end
      end else begin
        check("e_zero_when_invalid", E, 0);
      end
      if (DONE) begin
        if (done_q.size() == 0) flag_fail("unexpected_done");
        else begin
          mon_d = done_q.pop_front();
          check("done_cycle", cyc, mon_d);
        end
        check("bits_left_at_done", exp_q.size(), 0);
      end
    end
  end

  // Driver: load one pattern, push its reference stream, then run to completion.
  // stop_t = SEND cycle (1-based) in which STOP is pulsed (repeat mode only).
  task automatic send(input logic [WIDTH-1:0] pat, input int len_in, input bit rep,
                      input int stop_t, input bit poke);
    int L, passes, k, n;
    L = (len_in == 0 || len_in > WIDTH) ? WIDTH : len_in;
    @(negedge CLK);
    n = 0;
    while (!LOAD_READY && n < 100) begin @(negedge CLK); n++; end
    PATTERN = pat; LEN = len_in[LW-1:0]; REPEAT = rep; LOAD_VALID = 1'b1;
    @(posedge CLK); #1;
    LOAD_VALID = 1'b0;
    k = cyc;
    passes = rep ? ((stop_t - 1) / (L * HOLD) + 1) : 1;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < L; i++)
        for (int h = 0; h < HOLD; h++)
          exp_q.push_back(pat[i]);
    done_q.push_back(k + passes * L * HOLD);
    if (poke) begin
      PATTERN = '1; LEN = '0; REPEAT = 1'b1; LOAD_VALID = 1'b1;
    end
    if (rep) begin
      repeat (stop_t - 1) @(posedge CLK);
      #1 STOP = 1'b1;
      @(posedge CLK);
      #1 STOP = 1'b0;
    end
    n = 0;
    while (n < 2000) begin
      @(negedge CLK);
      if (poke) check("ready_low_while_busy", LOAD_READY, 0);
      if (DONE) break;
      n++;
    end
    LOAD_VALID = 1'b0;
    if (n >= 2000) flag_fail("done_timeout");
    @(negedge CLK);
    check("ready_after_done", LOAD_READY, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, LOAD_READY, 1);
    check({tag, "_e"}, E, 0);
    check({tag, "_evalid"}, E_VALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
  endtask

  // Reset in the middle of a pass: abort at once, never a DONE pulse.
  task automatic reset_mid_send();
    mon_en = 1'b0;
    @(negedge CLK);
    PATTERN = 8'hA5; LEN = LW'(8); REPEAT = 1'b0; LOAD_VALID = 1'b1;
    @(posedge CLK); #1;
    LOAD_VALID = 1'b0;
    repeat (3 * HOLD) @(posedge CLK);
    #1;
    check("rst_mid_bit3_valid", E_VALID, 1);
    check("rst_mid_bit3_e", E, 0);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check_idle_outputs("rst_mid");
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      check("rst_mid_no_done", DONE, 0);
    end
    mon_en = 1'b1;
  endtask

  initial begin
    int L;
    int len_r;
    bit rep_r;
    RST_N = 1'b0; LOAD_VALID = 1'b0; PATTERN = '0; LEN = '0; REPEAT = 1'b0; STOP = 1'b0;
    // Reset held for several edges: outputs stay at the idle values.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      check_idle_outputs("reset");
    end
    RST_N = 1'b1;
    mon_en = 1'b1;

    // Directed cases.
    send(8'b0000_0110, 4, 1'b0, 0, 1'b0);   // basic send
    send(8'h81, 0, 1'b0, 0, 1'b0);          // LEN=0 clamps to 8
    send(8'h81, 15, 1'b0, 0, 1'b0);         // LEN=15 clamps to 8
    send(8'b011, 3, 1'b1, 2 * 3 * HOLD + HOLD + 1, 1'b0);  // STOP in bit 1 of pass 3
    send(8'b101, 3, 1'b1, 3 * HOLD, 1'b0);  // STOP on the wrap cycle: one pass
    send(8'h5C, 5, 1'b1, 1, 1'b0);          // STOP in the first cycle: one pass
    send(8'h00, 8, 1'b0, 0, 1'b1);          // load attempt while busy is ignored
    reset_mid_send();
    send(8'h3C, 6, 1'b0, 0, 1'b0);          // normal operation after abort

    // Random traffic.
    for (int t = 0; t < 25; t++) begin
      len_r = $urandom_range(0, 15);
      rep_r = ($urandom_range(0, 2) == 0);
      L = (len_r == 0 || len_r > WIDTH) ? WIDTH : len_r;
      send(WIDTH'($urandom), len_r, rep_r, $urandom_range(1, 3 * L * HOLD),
           !rep_r && ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(negedge CLK);
    check("final_bits_drained", exp_q.size(), 0);
    check("final_done_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
